tp_pattern_scheduler: RTL and testbench
=======================================

Name: tp_pattern_scheduler

Overview:
Frame-synchronous controller for the test-pattern generator. It drives the generator's mode select and single-colour inputs. In manual mode it passes a host-selected mode through. In auto mode it steps a fixed pattern playlist every I_dwell_frames frames, with a "next" request that advances early. All changes take effect only at the frame-start instant, so no frame is ever torn. It sits beside the generator and reads back the generator's own VS output.

Parameters:
PAL_W, 2, palette index width (4 single colours: red, green, blue, white).
FCNT_W, 16, frame counter width.

Ports:
I_pxl_clk  in  1  pixel clock; single clock domain.
I_rst_n  in  1  asynchronous active-low reset.
I_vs  in  1  VS from the pattern generator, same clock domain.
I_vs_pol  in  1  VS polarity: 0 = active-low, 1 = active-high.
I_auto_en  in  1  1 = auto playlist, 0 = manual.
I_manual_mode  in  3  mode code used in manual state.
I_overlay_en  in  1  drives the moving-white-line overlay bit, O_mode[3].
I_next  in  1  level input; a rising edge requests an early playlist advance.
I_dwell_frames  in  8  frames per playlist entry; 0 is treated as 1.
O_mode  out  4  {overlay, mode[2:0]} to the generator.
O_single_r / O_single_g / O_single_b  out  8 each  single-colour value.
O_mode_chg  out  1  one-cycle pulse when O_mode changes.
O_frame_cnt  out  FCNT_W  free-running frame counter.
O_state  out  2  0 = MANUAL, 1 = AUTO (debug).

Behaviour:
- Sync normalisation: vsn = I_vs_pol ? I_vs : ~I_vs, registered to vsn_d1.
- Frame start: fs = vsn & ~vsn_d1, combinational in cycle k. Every output update caused by fs is registered and is visible in cycle k+1.
- Reset values:
  - O_mode = 4'b0000, O_single_* = 8'hFF, 8'h00, 8'h00 (red palette index 0).
  - O_mode_chg = 0, O_frame_cnt = 0, state = MANUAL.
  - Playlist index = 0, dwell counter = 0, next-pending = 0, vsn_d1 = 0.
  - Reset mid-frame gives the same values immediately (asynchronous).
- Playlist: index 0..5 maps to modes 000, 001, 010, 011, 100, 111. Index 5 wraps to 0.
- O_frame_cnt: +1 on every fs in any state; wraps from all-ones to 0.
- next-pending: set on an I_next rising edge (registered edge detect); cleared on fs. An edge and fs in the same cycle leave pending set for the following frame.
- MANUAL state, on fs:
  - O_mode = {I_overlay_en, I_manual_mode}.
  - If I_auto_en = 1: go to AUTO, index = 0, dwell = 0, O_mode = {I_overlay_en, 000}.
  - Between fs events O_mode holds, whatever the inputs do.
- AUTO state, on fs, first matching rule wins:
  - I_auto_en = 0: go to MANUAL, apply I_manual_mode, clear pending.
  - Pending = 1: advance index, dwell = 0.
  - dwell >= max(I_dwell_frames, 1) - 1: advance index, dwell = 0.
  - Otherwise: dwell + 1.
  - Overlay bit re-sampled every fs.
- Palette: index advances (wraps 3 to 0) each time AUTO enters playlist index 5 (mode 111). O_single_* = palette[idx]: FF0000, 00FF00, 0000FF, FFFFFF (r,g,b). Held in MANUAL.
- O_mode_chg: 1 in cycle k+1 iff the new O_mode differs from the old one, else 0. Never asserted without fs.
- I_dwell_frames changed mid-dwell: the new value applies at the next fs comparison. If dwell already exceeds the new limit, advance at that fs.

Test Plan:
- Reset then I_vs_pol = 0, 3 active-low VS pulses, I_manual_mode = 001 set between pulses → O_mode stays 0000 until the next falling VS edge, then 0001 one clock later with O_mode_chg high for exactly 1 cycle; O_frame_cnt = 3.
- I_auto_en = 1, I_dwell_frames = 2, 14 frames → O_mode sequence 0,0,1,1,2,2,3,3,4,4,7,7,0,0. O_single = FF0000 at first entry to 7, 00FF00 at second entry.
- I_dwell_frames = 0, auto → mode advances on every fs; no stall.
- Auto with dwell = 200, pulse I_next mid-frame → advance at the next fs; dwell restarts so the next advance comes 200 frames later. An I_next edge in the exact fs cycle → advance at the following fs.
- In auto, drop I_auto_en and pulse I_next in the same frame → at fs go to MANUAL with I_manual_mode applied; pending cleared, no extra advance after re-entering AUTO.
- I_vs_pol = 1 with active-high VS → same sequencing as the pol = 0 case. Assert I_rst_n low mid-frame → all outputs at reset values immediately.

Source files
------------

// File: rtl/tp_pattern_scheduler.sv
// Frame-synchronous mode/colour scheduler for the test-pattern generator.
// Manual pass-through or auto playlist; every update lands on the frame-start edge.
module tp_pattern_scheduler #(
  parameter int PAL_W  = 2,
  parameter int FCNT_W = 16
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst_n,
  input  logic              I_vs,
  input  logic              I_vs_pol,
  input  logic              I_auto_en,
  input  logic [2:0]        I_manual_mode,
  input  logic              I_overlay_en,
  input  logic              I_next,
  input  logic [7:0]        I_dwell_frames,
  output logic [3:0]        O_mode,
  output logic [7:0]        O_single_r,
  output logic [7:0]        O_single_g,
  output logic [7:0]        O_single_b,
  output logic              O_mode_chg,
  output logic [FCNT_W-1:0] O_frame_cnt,
  output logic [1:0]        O_state
);

  typedef enum logic [1:0] {ST_MANUAL = 2'd0, ST_AUTO = 2'd1} state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d, nidx;
  logic [7:0]        dwell_q, dwell_d, lim_m1;
  logic              pend_q, pend_d;
  logic              vsn_q, next_q;
  logic [PAL_W-1:0]  pal_q, pal_d;
  logic [3:0]        mode_q, mode_d;
  logic [23:0]       single_q, single_d;
  logic              chg_q, chg_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              vsn, fs, next_rise;

  function automatic logic [2:0] pl_mode(input logic [2:0] i);
    case (i)
      3'd0:    pl_mode = 3'b000;
      3'd1:    pl_mode = 3'b001;
      3'd2:    pl_mode = 3'b010;
      3'd3:    pl_mode = 3'b011;
      3'd4:    pl_mode = 3'b100;
      default: pl_mode = 3'b111;
    endcase
  endfunction

  function automatic logic [23:0] pal_rgb(input logic [PAL_W-1:0] p);
    case (p)
      PAL_W'(0): pal_rgb = 24'hFF0000;
      PAL_W'(1): pal_rgb = 24'h00FF00;
      PAL_W'(2): pal_rgb = 24'h0000FF;
      default:   pal_rgb = 24'hFFFFFF;
    endcase
  endfunction

  assign vsn       = I_vs_pol ? I_vs : ~I_vs;
  assign fs        = vsn & ~vsn_q;
  assign next_rise = I_next & ~next_q;
  assign lim_m1    = (I_dwell_frames == 8'd0) ? 8'd0 : I_dwell_frames - 8'd1;
  assign nidx      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dwell_d  = dwell_q;
    pal_d    = pal_q;
    mode_d   = mode_q;
    single_d = single_q;
    fcnt_d   = fcnt_q;
    pend_d   = pend_q | next_rise;
    chg_d    = 1'b0;
    if (fs) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
      // An edge coinciding with fs survives to request the following frame.
      pend_d = next_rise;
      case (state_q)
        ST_MANUAL: begin
          if (I_auto_en) begin
            state_d = ST_AUTO;
            idx_d   = 3'd0;
            dwell_d = 8'd0;
            mode_d  = {I_overlay_en, 3'b000};
          end else begin
            mode_d  = {I_overlay_en, I_manual_mode};
          end
        end
        default: begin
          if (!I_auto_en) begin
            state_d = ST_MANUAL;
            mode_d  = {I_overlay_en, I_manual_mode};
            pend_d  = 1'b0;
          end else if (pend_q || dwell_q >= lim_m1) begin
            idx_d   = nidx;
            dwell_d = 8'd0;
            mode_d  = {I_overlay_en, pl_mode(nidx)};
            // The colour shown for this mode-111 pass is the current palette
            // slot; the slot then steps on for the next pass.
            if (nidx == 3'd5) begin
              single_d = pal_rgb(pal_q);
              pal_d    = (pal_q == PAL_W'(3)) ? PAL_W'(0) : pal_q + PAL_W'(1);
            end
          end else begin
            dwell_d = dwell_q + 8'd1;
            mode_d  = {I_overlay_en, pl_mode(idx_q)};
          end
        end
      endcase
      chg_d = (mode_d != mode_q);
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= ST_MANUAL;
      idx_q    <= 3'd0;
      dwell_q  <= 8'd0;
      pend_q   <= 1'b0;
      vsn_q    <= 1'b0;
      next_q   <= 1'b0;
      pal_q    <= '0;
      mode_q   <= 4'b0000;
      single_q <= 24'hFF0000;
      chg_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dwell_q  <= dwell_d;
      pend_q   <= pend_d;
      vsn_q    <= vsn;
      next_q   <= I_next;
      pal_q    <= pal_d;
      mode_q   <= mode_d;
      single_q <= single_d;
      chg_q    <= chg_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign O_mode      = mode_q;
  assign O_single_r  = single_q[23:16];
  assign O_single_g  = single_q[15:8];
  assign O_single_b  = single_q[7:0];
  assign O_mode_chg  = chg_q;
  assign O_frame_cnt = fcnt_q;
  assign O_state     = state_q;

endmodule

// File: tb/tb_tp_pattern_scheduler.sv
// Scoreboard bench for tp_pattern_scheduler: expected per-frame outputs are
// queued as each VS pulse is driven and compared one clock after frame start.
module tb_tp_pattern_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs, vs_pol, auto_en, overlay_en, nxt;
  logic [2:0]  manual_mode;
  logic [7:0]  dwell_frames;
  logic [3:0]  mode;
  logic [7:0]  sr, sg, sb_;
  logic        mode_chg;
  logic [15:0] frame_cnt;
  logic [1:0]  state;

  always #5 clk = ~clk;

  tp_pattern_scheduler #(.PAL_W(2), .FCNT_W(16)) dut (
    .I_pxl_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_vs_pol(vs_pol),
    .I_auto_en(auto_en), .I_manual_mode(manual_mode), .I_overlay_en(overlay_en),
    .I_next(nxt), .I_dwell_frames(dwell_frames), .O_mode(mode),
    .O_single_r(sr), .O_single_g(sg), .O_single_b(sb_), .O_mode_chg(mode_chg),
    .O_frame_cnt(frame_cnt), .O_state(state)
  );

  typedef struct packed {
    logic [3:0]  mode;
    logic        chg;
    logic [23:0] rgb;
    logic        chk_rgb;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          checks = 0, passes = 0;
  int          fcnt_exp;
  logic [3:0]  prev_mode;
  logic [3:0]  ob_mode;
  logic        ob_chg, ob_chg2;
  logic [23:0] ob_rgb;
  logic [2:0]  pl [0:5];

  task automatic push(input logic [3:0] m, input logic [23:0] rgb, input logic chk);
    exp_t x;
    x.mode = m; x.chg = (m != prev_mode); x.rgb = rgb; x.chk_rgb = chk;
    sbq.push_back(x);
    prev_mode = m;
  endtask

  task automatic apply_reset(input logic pol);
    rst_n = 1'b0; vs_pol = pol; vs = ~pol; auto_en = 1'b0; overlay_en = 1'b0;
    nxt = 1'b0; manual_mode = 3'b000; dwell_frames = 8'd1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fcnt_exp = 0; prev_mode = 4'b0000; sbq.delete();
    @(negedge clk);
  endtask

  // One VS pulse; captures outputs in the cycle after fs and the cycle after that.
  task automatic run_frame(input logic nx_at_fs);
    @(posedge clk); #1;
    vs = vs_pol;
    if (nx_at_fs) nxt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ob_mode = mode; ob_chg = mode_chg; ob_rgb = {sr, sg, sb_};
    @(negedge clk);
    ob_chg2 = mode_chg;
    @(posedge clk); #1;
    vs = ~vs_pol; nxt = 1'b0;
    repeat (2) @(posedge clk);
    fcnt_exp++;
  endtask

  task automatic pulse_next();
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    checks++; if (mode !== 4'b0000) $display("FAIL reset_mode got %h want 0", mode); else passes++;
    checks++; if ({sr, sg, sb_} !== 24'hFF0000) $display("FAIL reset_rgb got %h want FF0000", {sr, sg, sb_}); else passes++;
    checks++; if (mode_chg !== 1'b0) $display("FAIL reset_chg got %b want 0", mode_chg); else passes++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_fcnt got %0d want 0", frame_cnt); else passes++;
    checks++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else passes++;
  endtask

  task automatic test_manual();
    apply_reset(1'b0);
    for (int f = 0; f < 3; f++) begin
      if (f == 2) begin
        manual_mode = 3'b001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mode !== 4'b0000 || mode_chg !== 1'b0)
          $display("FAIL manual_hold got mode=%h chg=%b want 0/0", mode, mode_chg);
        else passes++;
      end
      push({1'b0, manual_mode}, 24'hFF0000, 1'b1);
      run_frame(1'b0);
      e = sbq.pop_front();
      checks++;
      if (ob_mode !== e.mode || ob_chg !== e.chg || ob_chg2 !== 1'b0 || ob_rgb !== e.rgb)
        $display("FAIL manual_f%0d got mode=%h chg=%b,%b rgb=%h want mode=%h chg=%b,0 rgb=%h",
                 f, ob_mode, ob_chg, ob_chg2, ob_rgb, e.mode, e.chg, e.rgb);
      else passes++;
    end
    checks++; if (frame_cnt !== 16'(fcnt_exp)) $display("FAIL manual_fcnt got %0d want %0d", frame_cnt, fcnt_exp); else passes++;
    checks++; if (state !== 2'd0) $display("FAIL manual_state got %0d want 0", state); else passes++;
  endtask

  task automatic test_auto_dwell2();
    apply_reset(1'b0);
    auto_en = 1'b1; dwell_frames = 8'd2;
    for (int f = 0; f < 24; f++) begin
      push({1'b0, pl[(f / 2) % 6]}, (f < 22) ? 24'hFF0000 : 24'h00FF00, 1'b1);
      run_frame(1'b0);
      e = sbq.pop_front();
      checks++;
      if (ob_mode !== e.mode || ob_chg !== e.chg || ob_chg2 !== 1'b0 || ob_rgb !== e.rgb)
        $display("FAIL dwell2_f%0d got mode=%h chg=%b,%b rgb=%h want mode=%h chg=%b,0 rgb=%h",
                 f, ob_mode, ob_chg, ob_chg2, ob_rgb, e.mode, e.chg, e.rgb);
      else passes++;
    end
    checks++; if (state !== 2'd1) $display("FAIL dwell2_state got %0d want 1", state); else passes++;
    checks++; if (frame_cnt !== 16'(fcnt_exp)) $display("FAIL dwell2_fcnt got %0d want %0d", frame_cnt, fcnt_exp); else passes++;
  endtask

  task automatic test_dwell0();
    apply_reset(1'b0);
    auto_en = 1'b1; dwell_frames = 8'd0; overlay_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      push({1'b1, pl[f % 6]}, 24'hFF0000, 1'b1);
      run_frame(1'b0);
      e = sbq.pop_front();
      checks++;
      if (ob_mode !== e.mode || ob_chg !== e.chg || ob_chg2 !== 1'b0 || ob_rgb !== e.rgb)
        $display("FAIL dwell0_f%0d got mode=%h chg=%b,%b rgb=%h want mode=%h chg=%b,0 rgb=%h",
                 f, ob_mode, ob_chg, ob_chg2, ob_rgb, e.mode, e.chg, e.rgb);
      else passes++;
    end
  endtask

  task automatic test_next();
    apply_reset(1'b0);
    auto_en = 1'b1; dwell_frames = 8'd200;
    for (int f = 0; f < 204; f++) begin
      logic nx;
      nx = (f == 202);
      if (f == 1) pulse_next();
      // entry, early advance, 199 dwell frames, timed advance, fs-edge frame, deferred advance
      if (f == 0)        push(4'd0, 24'h0, 1'b0);
      else if (f <= 200) push(4'd1, 24'h0, 1'b0);
      else if (f <= 202) push(4'd2, 24'h0, 1'b0);
      else               push(4'd3, 24'h0, 1'b0);
      run_frame(nx);
      e = sbq.pop_front();
      checks++;
      if (ob_mode !== e.mode || ob_chg !== e.chg || ob_chg2 !== 1'b0)
        $display("FAIL next_f%0d got mode=%h chg=%b,%b want mode=%h chg=%b,0",
                 f, ob_mode, ob_chg, ob_chg2, e.mode, e.chg);
      else passes++;
    end
  endtask

  task automatic test_auto_drop();
    apply_reset(1'b0);
    auto_en = 1'b1; dwell_frames = 8'd200;
    for (int f = 0; f < 6; f++) begin
      if (f == 2) begin
        auto_en = 1'b0; manual_mode = 3'b010;
        pulse_next();
      end
      if (f == 4) auto_en = 1'b1;
      push((f == 2 || f == 3) ? 4'b0010 : 4'b0000, 24'h0, 1'b0);
      run_frame(1'b0);
      e = sbq.pop_front();
      checks++;
      if (ob_mode !== e.mode || ob_chg !== e.chg || ob_chg2 !== 1'b0)
        $display("FAIL drop_f%0d got mode=%h chg=%b,%b want mode=%h chg=%b,0",
                 f, ob_mode, ob_chg, ob_chg2, e.mode, e.chg);
      else passes++;
      if (f == 2) begin
        checks++; if (state !== 2'd0) $display("FAIL drop_state got %0d want 0", state); else passes++;
      end
    end
    checks++; if (state !== 2'd1) $display("FAIL drop_reenter got %0d want 1", state); else passes++;
  endtask

  task automatic test_pol1_and_reset();
    apply_reset(1'b1);
    manual_mode = 3'b011; overlay_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      if (f == 1) begin auto_en = 1'b1; dwell_frames = 8'd1; end
      push((f == 0) ? 4'hB : {1'b1, pl[f - 1]}, 24'hFF0000, 1'b1);
      run_frame(1'b0);
      e = sbq.pop_front();
      checks++;
      if (ob_mode !== e.mode || ob_chg !== e.chg || ob_chg2 !== 1'b0 || ob_rgb !== e.rgb)
        $display("FAIL pol1_f%0d got mode=%h chg=%b,%b rgb=%h want mode=%h chg=%b,0 rgb=%h",
                 f, ob_mode, ob_chg, ob_chg2, ob_rgb, e.mode, e.chg, e.rgb);
      else passes++;
    end
    checks++; if (frame_cnt !== 16'(fcnt_exp)) $display("FAIL pol1_fcnt got %0d want %0d", frame_cnt, fcnt_exp); else passes++;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mode !== 4'b0000 || {sr, sg, sb_} !== 24'hFF0000 || mode_chg !== 1'b0 ||
        frame_cnt !== 16'd0 || state !== 2'd0)
      $display("FAIL async_reset got mode=%h rgb=%h chg=%b fcnt=%0d st=%0d want 0/FF0000/0/0/0",
               mode, {sr, sg, sb_}, mode_chg, frame_cnt, state);
    else passes++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    pl[0] = 3'b000; pl[1] = 3'b001; pl[2] = 3'b010;
    pl[3] = 3'b011; pl[4] = 3'b100; pl[5] = 3'b111;
    test_reset();
    test_manual();
    test_auto_dwell2();
    test_dwell0();
    test_next();
    test_auto_drop();
    test_pol1_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
